dds_write_sequencer: RTL and testbench

DDS_WRITE_SEQUENCER -- requirements
Module: dds_write_sequencer

---
 rtl/dds_write_sequencer_if.sv | 33 +++
 rtl/dds_write_sequencer.sv | 157 +++++++++++++++
 tb/tb_dds_write_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_write_sequencer_if.sv
// rtl/dds_write_sequencer_if.sv - command and register-writer handshake bundle for dds_write_sequencer
//
// Signals:
//   cmd_valid / cmd_ready            host command handshake
//   cmd_bytes, cmd_data, cmd_update  command payload (data MSB-first, left-justified)
//   registerData_Bytes, registerData request payload to the SPI register writer
//   registerDataReady                request to the SPI register writer
//   writer_busy                      busy flag returned by the SPI register writer
// Modports: slave = the sequencer, master = host plus register writer side.
interface dds_write_sequencer_if #(
    parameter int LENGTH_BIT_COUNT = 3,
    parameter int MAXLENGTH8       = 56
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [LENGTH_BIT_COUNT-1:0] cmd_bytes;
    logic [MAXLENGTH8-1:0]       cmd_data;
    logic                        cmd_update;
    logic [LENGTH_BIT_COUNT-1:0] registerData_Bytes;
    logic [MAXLENGTH8-1:0]       registerData;
    logic                        registerDataReady;
    logic                        writer_busy;

    modport slave (
        input  cmd_valid, cmd_bytes, cmd_data, cmd_update, writer_busy,
        output cmd_ready, registerData_Bytes, registerData, registerDataReady
    );

    modport master (
        output cmd_valid, cmd_bytes, cmd_data, cmd_update, writer_busy,
        input  cmd_ready, registerData_Bytes, registerData, registerDataReady
    );
endinterface

// File: rtl/dds_write_sequencer.sv
// rtl/dds_write_sequencer.sv - queues DDS register writes and sequences them to an SPI register writer
//
// Ports:
//   SPI_clk       sole clock, rising edge
//   rst_n         synchronous active-low reset
//   bus           dds_write_sequencer_if.slave (command handshake and writer request/busy)
//   io_update     DDS IO_UPDATE strobe, UPDATE_CYCLES clocks long
//   fifo_count    number of queued commands
//   seq_idle      FSM idle, queue empty and writer not busy
//   err_zero_len  one-clock pulse when a zero-length command is dropped
//   err_timeout   one-clock pulse when a request is abandoned because writer_busy never rose
module dds_write_sequencer #(
    parameter int LENGTH_BIT_COUNT = 3,
    parameter int MAXLENGTH        = 7,
    parameter int MAXLENGTH8       = MAXLENGTH * 8,
    parameter int FIFO_AW          = 2,
    parameter int UPDATE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                  SPI_clk,
    input  logic                  rst_n,
    dds_write_sequencer_if.slave  bus,
    output logic                  io_update,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  seq_idle,
    output logic                  err_zero_len,
    output logic                  err_timeout
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               EW        = LENGTH_BIT_COUNT + MAXLENGTH8 + 1;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       UPD_LAST  = 8'(UPDATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, UPDATE} state_t;

    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               ready_q;     // low during reset and on the first clock of it
    logic               nonempty_q;  // count!=0 one clock late; forces a 2-clock push-to-issue latency
    logic               cmd_ready_c;
    logic               take;
    logic               push;
    logic               pop;
    logic [EW-1:0]      head;

    state_t             state;
    logic               upd_q;
    logic [7:0]         tmo_cnt;
    logic [7:0]         upd_cnt;

    // Ready looks only at the registered count; a pop in the same clock does not free a slot early.
    assign cmd_ready_c   = ready_q && (count < DEPTH_CNT);
    assign bus.cmd_ready = cmd_ready_c;
    assign take          = bus.cmd_valid && cmd_ready_c;
    assign push          = take && (bus.cmd_bytes != '0);
    // Waiting for writer_busy low in IDLE also covers a reset that lands mid-frame.
    assign pop           = (state == IDLE) && nonempty_q && (count != '0) && !bus.writer_busy;
    assign head          = mem[rd_ptr];
    assign fifo_count    = count;
    assign seq_idle      = ready_q && (state == IDLE) && (count == '0) && !bus.writer_busy;

    always_ff @(posedge SPI_clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_bytes, bus.cmd_data, bus.cmd_update};
        end
    end

    always_ff @(posedge SPI_clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ready_q      <= 1'b0;
            nonempty_q   <= 1'b0;
            err_zero_len <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            nonempty_q   <= (count != '0);
            err_zero_len <= take && (bus.cmd_bytes == '0);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SPI_clk) begin
        if (!rst_n) begin
            state                  <= IDLE;
            upd_q                  <= 1'b0;
            tmo_cnt                <= '0;
            upd_cnt                <= '0;
            io_update              <= 1'b0;
            err_timeout            <= 1'b0;
            bus.registerDataReady  <= 1'b0;
            bus.registerData       <= '0;
            bus.registerData_Bytes <= '0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.registerData_Bytes <= head[EW-1 -: LENGTH_BIT_COUNT];
                        bus.registerData       <= head[MAXLENGTH8:1];
                        upd_q                  <= head[0];
                        bus.registerDataReady  <= 1'b1;
                        tmo_cnt                <= '0;
                        state                  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.writer_busy) begin
                        bus.registerDataReady <= 1'b0;
                        state                 <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Command already popped; dropping it here also drops its update request.
                        bus.registerDataReady <= 1'b0;
                        err_timeout           <= 1'b1;
                        state                 <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.writer_busy) begin
                        if (upd_q) begin
                            io_update <= 1'b1;
                            upd_cnt   <= '0;
                            state     <= UPDATE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                UPDATE: begin
                    if (upd_cnt == UPD_LAST) begin
                        io_update <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        upd_cnt <= upd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_write_sequencer.sv
// tb/tb_dds_write_sequencer.sv - self-checking bench for dds_write_sequencer with writer model and scoreboard
module tb_dds_write_sequencer;
    localparam int LBC = 3;
    localparam int M8  = 56;
    localparam int FAW = 2;
    localparam int UPD = 4;
    localparam int TMO = 16;
    localparam int W   = LBC + M8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dds_write_sequencer_if #(.LENGTH_BIT_COUNT(LBC), .MAXLENGTH8(M8)) bus();

    logic           io_update;
    logic [FAW:0]   fifo_count;
    logic           seq_idle;
    logic           err_zero_len;
    logic           err_timeout;

    logic           h_valid = 1'b0;
    logic [LBC-1:0] h_bytes = '0;
    logic [M8-1:0]  h_data = '0;
    logic           h_update = 1'b0;
    logic           wbusy = 1'b0;

    assign bus.cmd_valid   = h_valid;
    assign bus.cmd_bytes   = h_bytes;
    assign bus.cmd_data    = h_data;
    assign bus.cmd_update  = h_update;
    assign bus.writer_busy = wbusy;

    dds_write_sequencer #(
        .LENGTH_BIT_COUNT(LBC), .MAXLENGTH(7), .MAXLENGTH8(M8),
        .FIFO_AW(FAW), .UPDATE_CYCLES(UPD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .SPI_clk(clk), .rst_n(rst_n), .bus(bus), .io_update(io_update),
        .fifo_count(fifo_count), .seq_idle(seq_idle),
        .err_zero_len(err_zero_len), .err_timeout(err_timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register writer: accepts a request a moment after the edge, stays busy busy_len clocks.
    int busy_len  = 26;
    bit writer_en = 1'b1;
    int wcnt      = 0;
    always @(posedge clk) begin
        #2;
        if (wcnt > 0) begin
            wcnt = wcnt - 1;
            if (wcnt == 0) wbusy = 1'b0;
        end else if (bus.registerDataReady && writer_en && !wbusy) begin
            wbusy = 1'b1;
            wcnt  = busy_len;
        end
    end

    // Observation of requests, strobes and error pulses.
    logic [W-1:0] rise_q[$];
    int           rise_cyc_q[$];
    int           rise_cnt_q[$];
    int           rdr_runs[$];
    int           io_runs[$];
    int           zl_cnt = 0, to_cnt = 0, overlap = 0, busy_viol = 0, full_ready_bad = 0, saw_full = 0;
    int           rdr_run = 0, io_run = 0;
    logic         rdr_prev = 1'b0, io_prev = 1'b0, busy_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.registerDataReady && !rdr_prev) begin
                rise_q.push_back({bus.registerData_Bytes, bus.registerData});
                rise_cyc_q.push_back(cyc);
                rise_cnt_q.push_back(int'(fifo_count));
                if (busy_prev) busy_viol++;
                rdr_run = 0;
            end
            if (bus.registerDataReady) rdr_run++;
            else if (rdr_prev) rdr_runs.push_back(rdr_run);
            if (io_update && !io_prev) io_run = 0;
            if (io_update) io_run++;
            else if (io_prev) io_runs.push_back(io_run);
            if (err_zero_len) zl_cnt++;
            if (err_timeout) to_cnt++;
            if (io_update && bus.registerDataReady) overlap++;
            if (fifo_count == 3'd4 && bus.cmd_ready) full_ready_bad++;
            if (fifo_count == 3'd4 && !bus.cmd_ready) saw_full++;
        end
        rdr_prev  = bus.registerDataReady;
        io_prev   = io_update;
        busy_prev = wbusy;
    end

    function automatic logic [M8-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[M8-1:0];
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic push_cmd(input logic [LBC-1:0] b, input logic [M8-1:0] d, input logic u, output int acc);
        logic r;
        acc = -1;
        h_valid = 1'b1; h_bytes = b; h_data = d; h_update = u;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            r = bus.cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                break;
            end
        end
        h_valid = 1'b0;
        if (acc < 0) begin
            total++; bad++;
            $display("FAIL push_accept got=never exp=accepted");
        end
    endtask

    task automatic wait_idle(input int maxc);
        bit ok;
        ok = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (seq_idle && wcnt == 0 && !io_update) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_idle got=busy exp=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.registerDataReady !== 1'b0) begin bad++; $display("FAIL reset_rdr got=%0b exp=0", bus.registerDataReady); end
        total++; if (io_update !== 1'b0) begin bad++; $display("FAIL reset_io got=%0b exp=0", io_update); end
        total++; if (err_zero_len !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b%0b exp=00", err_zero_len, err_timeout); end
        total++; if (bus.registerData !== '0 || bus.registerData_Bytes !== '0) begin bad++; $display("FAIL reset_data got=%0h/%0h exp=0", bus.registerData, bus.registerData_Bytes); end
        total++; if (seq_idle !== 1'b0) begin bad++; $display("FAIL reset_idle got=%0b exp=0", seq_idle); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", bus.cmd_ready); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b exp=1", bus.cmd_ready); end
        total++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%0b exp=1", seq_idle); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_update();
        int s_r, s_io, s_to, acc;
        logic [W-1:0] e;
        s_r = rise_q.size(); s_io = io_runs.size(); s_to = to_cnt;
        busy_len = 26;
        e = {3'd3, 56'h0E1234_00000000};
        push_cmd(3'd3, 56'h0E1234_00000000, 1'b1, acc);
        wait_idle(300);
        total++; if (rise_q.size() - s_r !== 1) begin bad++; $display("FAIL single_requests got=%0d exp=1", rise_q.size() - s_r); end
        if (rise_q.size() > s_r) begin
            total++; if (rise_q[s_r] !== e) begin bad++; $display("FAIL single_data got=%0h exp=%0h", rise_q[s_r], e); end
            total++; if (rise_cyc_q[s_r] - acc < 2) begin bad++; $display("FAIL single_latency got=%0d exp>=2", rise_cyc_q[s_r] - acc); end
        end
        total++; if (io_runs.size() - s_io !== 1) begin bad++; $display("FAIL single_io_pulses got=%0d exp=1", io_runs.size() - s_io); end
        if (io_runs.size() > s_io) begin
            total++; if (io_runs[s_io] !== UPD) begin bad++; $display("FAIL single_io_len got=%0d exp=%0d", io_runs[s_io], UPD); end
        end
        total++; if (to_cnt !== s_to) begin bad++; $display("FAIL single_timeout got=%0d exp=%0d", to_cnt, s_to); end
        @(negedge clk);
        total++; if (seq_idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%0b exp=1", seq_idle); end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        int s_r, s_io, s_full, s_frb, acc;
        logic [W-1:0] exp_q[$];
        logic [LBC-1:0] b;
        logic [M8-1:0] d;
        s_r = rise_q.size(); s_io = io_runs.size(); s_full = saw_full; s_frb = full_ready_bad;
        busy_len = 30;
        for (int i = 0; i < 6; i++) begin
            b = LBC'($urandom_range(1, 7));
            d = rnd_data();
            push_cmd(b, d, 1'b0, acc);
            exp_q.push_back({b, d});
        end
        wait_idle(800);
        total++; if (rise_q.size() - s_r !== 6) begin bad++; $display("FAIL burst_requests got=%0d exp=6", rise_q.size() - s_r); end
        for (int i = 0; i < 6 && s_r + i < rise_q.size(); i++) begin
            total++; if (rise_q[s_r + i] !== exp_q[i]) begin bad++; $display("FAIL burst_order[%0d] got=%0h exp=%0h", i, rise_q[s_r + i], exp_q[i]); end
        end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL burst_count got=%0d exp=0", fifo_count); end
        total++; if (io_runs.size() !== s_io) begin bad++; $display("FAIL burst_io got=%0d exp=0", io_runs.size() - s_io); end
        total++; if (!(saw_full > s_full)) begin bad++; $display("FAIL burst_backpressure got=%0d exp>0", saw_full - s_full); end
        total++; if (full_ready_bad !== s_frb) begin bad++; $display("FAIL burst_ready_when_full got=%0d exp=0", full_ready_bad - s_frb); end
    endtask

    task automatic test_zero_len();
        int s_r, s_io, s_zl, acc;
        logic [W-1:0] ea, eb;
        logic [M8-1:0] d;
        s_r = rise_q.size(); s_io = io_runs.size(); s_zl = zl_cnt;
        busy_len = int'($urandom_range(5, 20));
        d = rnd_data(); ea = {3'd7, d}; push_cmd(3'd7, d, 1'b0, acc);
        push_cmd(3'd0, rnd_data(), 1'b1, acc);
        d = rnd_data(); eb = {3'd1, d}; push_cmd(3'd1, d, 1'b0, acc);
        wait_idle(300);
        total++; if (zl_cnt - s_zl !== 1) begin bad++; $display("FAIL zero_len_pulses got=%0d exp=1", zl_cnt - s_zl); end
        total++; if (rise_q.size() - s_r !== 2) begin bad++; $display("FAIL zero_len_requests got=%0d exp=2", rise_q.size() - s_r); end
        if (rise_q.size() - s_r >= 2) begin
            total++; if (rise_q[s_r] !== ea) begin bad++; $display("FAIL zero_len_first got=%0h exp=%0h", rise_q[s_r], ea); end
            total++; if (rise_q[s_r + 1] !== eb) begin bad++; $display("FAIL zero_len_second got=%0h exp=%0h", rise_q[s_r + 1], eb); end
        end
        total++; if (io_runs.size() !== s_io) begin bad++; $display("FAIL zero_len_io got=%0d exp=0", io_runs.size() - s_io); end
    endtask

    task automatic test_timeout();
        int s_r, s_io, s_to, s_runs, acc;
        bit seen;
        logic [W-1:0] ea, eb;
        logic [M8-1:0] d;
        s_r = rise_q.size(); s_io = io_runs.size(); s_to = to_cnt; s_runs = rdr_runs.size();
        busy_len = 8;
        writer_en = 1'b0;
        d = rnd_data(); ea = {3'd2, d}; push_cmd(3'd2, d, 1'b1, acc);
        d = rnd_data(); eb = {3'd5, d}; push_cmd(3'd5, d, 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                seen = 1'b1;
                break;
            end
        end
        writer_en = 1'b1;
        total++; if (!seen) begin bad++; $display("FAIL timeout_seen got=0 exp=1"); end
        wait_idle(300);
        total++; if (to_cnt - s_to !== 1) begin bad++; $display("FAIL timeout_pulses got=%0d exp=1", to_cnt - s_to); end
        if (rdr_runs.size() > s_runs) begin
            total++; if (rdr_runs[s_runs] !== TMO) begin bad++; $display("FAIL timeout_rdr_len got=%0d exp=%0d", rdr_runs[s_runs], TMO); end
        end
        total++; if (rise_q.size() - s_r !== 2) begin bad++; $display("FAIL timeout_requests got=%0d exp=2", rise_q.size() - s_r); end
        if (rise_q.size() - s_r >= 2) begin
            total++; if (rise_q[s_r] !== ea) begin bad++; $display("FAIL timeout_first got=%0h exp=%0h", rise_q[s_r], ea); end
            total++; if (rise_q[s_r + 1] !== eb) begin bad++; $display("FAIL timeout_next got=%0h exp=%0h", rise_q[s_r + 1], eb); end
        end
        total++; if (io_runs.size() - s_io !== 1) begin bad++; $display("FAIL timeout_io got=%0d exp=1", io_runs.size() - s_io); end
    endtask

    task automatic test_reset_midop();
        int s_r, s_io, s_v, acc;
        bit seen;
        logic [W-1:0] e;
        logic [M8-1:0] d;
        busy_len = 40;
        push_cmd(3'd4, rnd_data(), 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wbusy && !bus.registerDataReady) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL midop_wait_done got=0 exp=1"); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.registerDataReady !== 1'b0 || io_update !== 1'b0) begin bad++; $display("FAIL midop_outputs got=%0b%0b exp=00", bus.registerDataReady, io_update); end
        total++; if (fifo_count !== '0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL midop_fifo got=%0d/%0b exp=0/0", fifo_count, bus.cmd_ready); end
        total++; if (bus.registerData !== '0 || seq_idle !== 1'b0) begin bad++; $display("FAIL midop_data got=%0h/%0b exp=0/0", bus.registerData, seq_idle); end
        @(posedge clk); #1; rst_n = 1'b1;
        s_r = rise_q.size(); s_io = io_runs.size(); s_v = busy_viol;
        d = rnd_data(); e = {3'd6, d};
        push_cmd(3'd6, d, 1'b0, acc);
        wait_idle(300);
        total++; if (busy_viol !== s_v) begin bad++; $display("FAIL midop_issue_while_busy got=%0d exp=0", busy_viol - s_v); end
        total++; if (rise_q.size() - s_r !== 1) begin bad++; $display("FAIL midop_requests got=%0d exp=1", rise_q.size() - s_r); end
        if (rise_q.size() > s_r) begin
            total++; if (rise_q[s_r] !== e) begin bad++; $display("FAIL midop_data_after got=%0h exp=%0h", rise_q[s_r], e); end
        end
        total++; if (io_runs.size() !== s_io) begin bad++; $display("FAIL midop_io got=%0d exp=0", io_runs.size() - s_io); end
    endtask

    task automatic test_full_pushpop();
        int s_r, acc, acc5;
        bit seen;
        logic [W-1:0] exp_q[$];
        logic [LBC-1:0] b;
        logic [M8-1:0] d;
        s_r = rise_q.size();
        busy_len = 20;
        b = LBC'($urandom_range(1, 7)); d = rnd_data();
        push_cmd(b, d, 1'b0, acc); exp_q.push_back({b, d});
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbusy) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL full_first_busy got=0 exp=1"); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            b = LBC'($urandom_range(1, 7)); d = rnd_data();
            push_cmd(b, d, 1'b0, acc); exp_q.push_back({b, d});
        end
        acc5 = acc;
        wait_idle(500);
        total++; if (rise_q.size() - s_r !== 6) begin bad++; $display("FAIL full_requests got=%0d exp=6", rise_q.size() - s_r); end
        for (int i = 0; i < 6 && s_r + i < rise_q.size(); i++) begin
            total++; if (rise_q[s_r + i] !== exp_q[i]) begin bad++; $display("FAIL full_order[%0d] got=%0h exp=%0h", i, rise_q[s_r + i], exp_q[i]); end
        end
        if (rise_q.size() - s_r >= 2) begin
            total++; if (acc5 !== rise_cyc_q[s_r + 1] + 1) begin bad++; $display("FAIL full_refused_then_accepted got=%0d exp=%0d", acc5, rise_cyc_q[s_r + 1] + 1); end
            total++; if (rise_cnt_q[s_r + 1] !== 3) begin bad++; $display("FAIL full_count_after_pop got=%0d exp=3", rise_cnt_q[s_r + 1]); end
        end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL full_count_end got=%0d exp=0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_burst();
        test_zero_len();
        test_timeout();
        test_reset_midop();
        test_full_pushpop();
        total++; if (overlap !== 0) begin bad++; $display("FAIL request_during_update got=%0d exp=0", overlap); end
        total++; if (full_ready_bad !== 0) begin bad++; $display("FAIL ready_when_full got=%0d exp=0", full_ready_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule
